// File: rtl/gate_selftest_seq_pkg.sv
// Shared definitions for the gate self-test sequencer.
// Holds the default sizing constants, the gate opcode numbering, the golden
// truth nibbles and the sequencer state encoding. The gate unit, the
// sequencer and the bench all use it.
// No ports (package).
package gate_selftest_seq_pkg;

    localparam int DEF_NUM_OPS = 6;
    localparam int DEF_OP_W    = 3;
    localparam int DEF_ERR_W   = 5;

    // Gate opcodes
    localparam logic [DEF_OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [DEF_OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [DEF_OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [DEF_OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [DEF_OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [DEF_OP_W-1:0] OP_XNOR = 3'd5;

    // Golden truth nibbles, bit index = {A,B}
    localparam logic [3:0] GOLD_AND  = 4'b1000;
    localparam logic [3:0] GOLD_OR   = 4'b1110;
    localparam logic [3:0] GOLD_XOR  = 4'b0110;
    localparam logic [3:0] GOLD_NAND = 4'b0111;
    localparam logic [3:0] GOLD_NOR  = 4'b0001;
    localparam logic [3:0] GOLD_XNOR = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Expected gate output for one opcode and one {A,B} input pair.
    // Unknown opcodes have no golden row and return 0.
    function automatic logic gold_bit(input logic [DEF_OP_W-1:0] op,
                                      input logic [1:0] ab);
        logic [3:0] nib;
        nib = 4'b0000;
        case (op)
            OP_AND:  nib = GOLD_AND;
            OP_OR:   nib = GOLD_OR;
            OP_XOR:  nib = GOLD_XOR;
            OP_NAND: nib = GOLD_NAND;
            OP_NOR:  nib = GOLD_NOR;
            OP_XNOR: nib = GOLD_XNOR;
            default: nib = 4'b0000;
        endcase
        return nib[ab];
    endfunction

endpackage

// File: rtl/gate_selftest_seq_gate_unit.sv
// Opcode-selected two-input gate with a registered output.
// This is the single shared gate that the sequencer exercises.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset, clears the result register
//   op     - gate opcode (AND, OR, XOR, NAND, NOR, XNOR)
//   a, b   - gate inputs
//   result - gate output, registered (one cycle after op/a/b)
module gate_unit
    import gate_selftest_seq_pkg::*;
#(
    parameter int OP_W = DEF_OP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] op,
    input  logic            a,
    input  logic            b,
    output logic            result
);

    logic gate_out;

    // Combinational gate chosen by opcode. Unused opcodes produce 0.
    always_comb begin
        gate_out = 1'b0;
        case (op)
            OP_AND:  gate_out = a & b;
            OP_OR:   gate_out = a | b;
            OP_XOR:  gate_out = a ^ b;
            OP_NAND: gate_out = ~(a & b);
            OP_NOR:  gate_out = ~(a | b);
            OP_XNOR: gate_out = ~(a ^ b);
            default: gate_out = 1'b0;
        endcase
    end

    // Result register: this gives the one-cycle latency from the issue
    // cycle to the check cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= 1'b0;
        end else begin
            result <= gate_out;
        end
    end

endmodule

// File: rtl/gate_selftest_seq.sv
// Built-in self-test sequencer for the two-input gate set.
// On start it walks every opcode across all four {A,B} combinations through
// one shared gate unit. It compares each registered result with the golden
// truth table, counts mismatches and ends the run with a one-cycle done pulse.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - begin a run (only looked at while idle)
//   fault_en     - invert the checked result for opcode fault_op
//   fault_op     - opcode targeted by fault injection
//   busy         - high while a run is in progress
//   done         - one-cycle pulse at the end of a run
//   pass         - last completed run had no mismatches (held until next done)
//   err_cnt      - mismatches in the current or last run
//   first_err_op - opcode of the first mismatch in the run
//   first_err_ab - {A,B} of the first mismatch in the run
//   cur_op       - opcode currently driven to the gate unit
//   cur_ab       - {A,B} currently driven to the gate unit
module gate_selftest_seq
    import gate_selftest_seq_pkg::*;
#(
    parameter int NUM_OPS = DEF_NUM_OPS,
    parameter int OP_W    = DEF_OP_W,
    parameter int ERR_W   = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             fault_en,
    input  logic [OP_W-1:0]  fault_op,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [OP_W-1:0]  first_err_op,
    output logic [1:0]       first_err_ab,
    output logic [OP_W-1:0]  cur_op,
    output logic [1:0]       cur_ab
);

    localparam logic [OP_W-1:0] LAST_OP = OP_W'(NUM_OPS - 1);

    state_t           state, state_n;
    logic [OP_W-1:0]  cur_op_n;
    logic [1:0]       cur_ab_n;
    logic [ERR_W-1:0] err_cnt_n;
    logic [OP_W-1:0]  first_err_op_n;
    logic [1:0]       first_err_ab_n;
    logic             err_seen, err_seen_n;
    logic             pass_n;
    logic             gate_result;
    logic             checked;

    gate_unit #(
        .OP_W (OP_W)
    ) u_gate (
        .clk    (clk),
        .rst    (rst),
        .op     (cur_op),
        .a      (cur_ab[1]),
        .b      (cur_ab[0]),
        .result (gate_result)
    );

    // An out-of-range fault_op never equals cur_op, so it injects nothing.
    assign checked = gate_result ^ (fault_en && (fault_op == cur_op));

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Next-state and datapath updates. Everything holds by default; the
    // vector walk advances only in CHECK, after the result has been judged.
    always_comb begin
        state_n        = state;
        cur_op_n       = cur_op;
        cur_ab_n       = cur_ab;
        err_cnt_n      = err_cnt;
        first_err_op_n = first_err_op;
        first_err_ab_n = first_err_ab;
        err_seen_n     = err_seen;
        pass_n         = pass;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    err_cnt_n      = '0;
                    first_err_op_n = '0;
                    first_err_ab_n = '0;
                    err_seen_n     = 1'b0;
                    cur_op_n       = '0;
                    cur_ab_n       = '0;
                    state_n        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_n = ST_CHECK;
            end
            ST_CHECK: begin
                if (checked != gold_bit(cur_op, cur_ab)) begin
                    err_cnt_n = err_cnt + ERR_W'(1);
                    if (!err_seen) begin
                        err_seen_n     = 1'b1;
                        first_err_op_n = cur_op;
                        first_err_ab_n = cur_ab;
                    end
                end
                if (cur_ab == 2'd3) begin
                    if (cur_op == LAST_OP) begin
                        state_n = ST_DONE;
                    end else begin
                        cur_ab_n = 2'd0;
                        cur_op_n = cur_op + OP_W'(1);
                        state_n  = ST_ISSUE;
                    end
                end else begin
                    cur_ab_n = cur_ab + 2'd1;
                    state_n  = ST_ISSUE;
                end
            end
            ST_DONE: begin
                // err_cnt already includes the final CHECK at this point
                pass_n  = (err_cnt == '0);
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cur_op       <= '0;
            cur_ab       <= '0;
            err_cnt      <= '0;
            first_err_op <= '0;
            first_err_ab <= '0;
            err_seen     <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state        <= state_n;
            cur_op       <= cur_op_n;
            cur_ab       <= cur_ab_n;
            err_cnt      <= err_cnt_n;
            first_err_op <= first_err_op_n;
            first_err_ab <= first_err_ab_n;
            err_seen     <= err_seen_n;
            pass         <= pass_n;
        end
    end

endmodule

// File: tb/tb_gate_selftest_seq.sv
// Self-checking bench for gate_selftest_seq.
// A behavioural model works out each run's expected mismatch count, first
// failing vector and pass flag from the gate truth rules and the fault
// schedule applied to each check. The bench covers table-driven fault runs,
// randomized fault schedules and hand-written corner sequences.
module tb_gate_selftest_seq;
    import gate_selftest_seq_pkg::*;

    localparam int NVEC = DEF_NUM_OPS * 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       fault_en;
    logic [2:0] fault_op;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_cnt;
    logic [2:0] first_err_op;
    logic [1:0] first_err_ab;
    logic [2:0] cur_op;
    logic [1:0] cur_ab;

    int total = 0;
    int bad = 0;
    logic model_pass = 1'b0;

    logic       sched_en [NVEC];
    logic [2:0] sched_op [NVEC];

    typedef struct {
        logic       f_en;
        logic [2:0] f_op;
        int         exp_err;
        int         exp_fop;
        int         exp_fab;
        int         exp_pass;
    } vec_t;

    vec_t table_v [8];

    gate_selftest_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .fault_en     (fault_en),
        .fault_op     (fault_op),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_cnt      (err_cnt),
        .first_err_op (first_err_op),
        .first_err_ab (first_err_ab),
        .cur_op       (cur_op),
        .cur_ab       (cur_ab)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Move to 1 time unit after the next rising edge: outputs are stable
    // there and inputs driven there are sampled at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_pass"}, int'(pass), 0);
        checkOutput({tag, "_err"}, int'(err_cnt), 0);
        checkOutput({tag, "_fop"}, int'(first_err_op), 0);
        checkOutput({tag, "_fab"}, int'(first_err_ab), 0);
        checkOutput({tag, "_cop"}, int'(cur_op), 0);
        checkOutput({tag, "_cab"}, int'(cur_ab), 0);
    endtask

    // Ideal two-input gate from plain boolean rules.
    function automatic logic ideal_gate(input int op, input logic a, input logic b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    // Expected run outcome: vector i is opcode i/4 with {A,B} = i%4. The
    // checked value is the ideal gate inverted when the fault active during
    // that check targets the vector's opcode.
    task automatic model_run(output int e, output int fo, output int fab);
        int op;
        int ab;
        logic ideal;
        logic seen;
        e = 0; fo = 0; fab = 0; seen = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            op = i / 4;
            ab = i % 4;
            ideal = ideal_gate(op, ab[1], ab[0]);
            if ((ideal ^ (sched_en[i] && int'(sched_op[i]) == op)) != ideal) begin
                e++;
                if (!seen) begin
                    seen = 1'b1;
                    fo = op;
                    fab = ab;
                end
            end
        end
    endtask

    // One complete run from IDLE using the current fault schedule. With
    // noise set, start is toggled randomly while busy, which must be ignored.
    task automatic applyStimulus(input bit noise);
        int e;
        int fo;
        int fab;
        int run_err;
        model_run(e, fo, fab);
        run_err = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            checkOutput("issue_busy", int'(busy), 1);
            checkOutput("issue_done", int'(done), 0);
            checkOutput("issue_op", int'(cur_op), i / 4);
            checkOutput("issue_ab", int'(cur_ab), i % 4);
            checkOutput("issue_err", int'(err_cnt), run_err);
            fault_en = sched_en[i];
            fault_op = sched_op[i];
            if (noise) start = 1'($urandom);
            tick();
            checkOutput("check_busy", int'(busy), 1);
            checkOutput("check_done", int'(done), 0);
            if (sched_en[i] && int'(sched_op[i]) == i / 4) run_err++;
            tick();
        end
        start = 1'b0;
        fault_en = 1'b0;
        checkOutput("done_pulse", int'(done), 1);
        checkOutput("done_busy", int'(busy), 1);
        checkOutput("done_err", int'(err_cnt), e);
        checkOutput("done_fop", int'(first_err_op), fo);
        checkOutput("done_fab", int'(first_err_ab), fab);
        checkOutput("done_pass_held", int'(pass), int'(model_pass));
        model_pass = (e == 0);
        tick();
        checkOutput("idle_done", int'(done), 0);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_pass", int'(pass), int'(model_pass));
        checkOutput("idle_err", int'(err_cnt), e);
    endtask

    task automatic setConstSchedule(input logic en, input logic [2:0] op);
        for (int i = 0; i < NVEC; i++) begin
            sched_en[i] = en;
            sched_op[i] = op;
        end
    endtask

    initial begin
        int first_t;
        int second_t;
        int n_done;
        int waited;

        table_v[0] = '{1'b0, 3'd0, 0, 0, 0, 1};
        table_v[1] = '{1'b1, 3'd2, 4, 2, 0, 0};
        table_v[2] = '{1'b0, 3'd2, 0, 0, 0, 1};
        table_v[3] = '{1'b1, 3'd7, 0, 0, 0, 1};
        table_v[4] = '{1'b1, 3'd0, 4, 0, 0, 0};
        table_v[5] = '{1'b1, 3'd5, 4, 5, 0, 0};
        table_v[6] = '{1'b1, 3'd6, 0, 0, 0, 1};
        table_v[7] = '{1'b1, 3'd3, 4, 3, 0, 0};

        rst = 1'b1;
        start = 1'b0;
        fault_en = 1'b0;
        fault_op = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        checkResetState("reset");
        tick();
        tick();

        // Constant-fault runs from the table
        for (int t = 0; t < 8; t++) begin
            setConstSchedule(table_v[t].f_en, table_v[t].f_op);
            applyStimulus(1'b0);
            checkOutput("tbl_err", int'(err_cnt), table_v[t].exp_err);
            checkOutput("tbl_fop", int'(first_err_op), table_v[t].exp_fop);
            checkOutput("tbl_fab", int'(first_err_ab), table_v[t].exp_fab);
            checkOutput("tbl_pass", int'(pass), table_v[t].exp_pass);
        end

        // Fault on opcode 5 only during the last two checks
        setConstSchedule(1'b0, 3'd5);
        sched_en[NVEC-2] = 1'b1;
        sched_en[NVEC-1] = 1'b1;
        applyStimulus(1'b0);
        checkOutput("tail_err", int'(err_cnt), 2);
        checkOutput("tail_fop", int'(first_err_op), 5);
        checkOutput("tail_fab", int'(first_err_ab), 2);
        checkOutput("tail_pass", int'(pass), 0);

        // Every check faulted: 24 mismatches, the most the counter sees
        for (int i = 0; i < NVEC; i++) begin
            sched_en[i] = 1'b1;
            sched_op[i] = 3'(i / 4);
        end
        applyStimulus(1'b0);
        checkOutput("all_err", int'(err_cnt), 24);

        // Random per-check fault schedules, with start noise while busy
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NVEC; i++) begin
                sched_en[i] = ($urandom_range(0, 2) == 0);
                sched_op[i] = ($urandom_range(0, 1) == 1) ? 3'(i / 4)
                                                         : 3'($urandom_range(0, 7));
            end
            applyStimulus(1'b1);
        end

        // Clean run so the held-start runs follow a known pass state
        setConstSchedule(1'b0, 3'd0);
        applyStimulus(1'b0);

        // start held high: back-to-back runs, done pulses 50 cycles apart
        first_t = -1;
        second_t = -1;
        n_done = 0;
        start = 1'b1;
        for (int t = 1; t <= 120; t++) begin
            tick();
            if (done) begin
                n_done++;
                checkOutput("held_err", int'(err_cnt), 0);
                if (first_t < 0) first_t = t;
                else if (second_t < 0) second_t = t;
            end
        end
        start = 1'b0;
        checkOutput("held_count", n_done, 2);
        checkOutput("held_first", first_t, 49);
        checkOutput("held_gap", second_t - first_t, 50);
        waited = 0;
        while (!done && waited < 100) begin
            tick();
            waited++;
        end
        checkOutput("held_third_done", int'(done), 1);
        tick();
        checkOutput("held_idle_busy", int'(busy), 0);
        checkOutput("held_pass", int'(pass), 1);
        model_pass = 1'b1;

        // Reset wins over start in the same cycle
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        checkOutput("prio_busy", int'(busy), 0);
        checkOutput("prio_pass", int'(pass), 0);
        tick();
        checkOutput("prio_busy2", int'(busy), 0);
        model_pass = 1'b0;

        // Clean run restores pass, then a faulted run is reset at cycle 20
        applyStimulus(1'b0);
        fault_en = 1'b1;
        fault_op = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        checkOutput("mid_busy_before", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fault_en = 1'b0;
        checkResetState("midrst");
        model_pass = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("midrst_no_done", int'(done), 0);
            checkOutput("midrst_idle", int'(busy), 0);
        end
        setConstSchedule(1'b0, 3'd0);
        applyStimulus(1'b0);
        checkOutput("after_rst_pass", int'(pass), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
